// File: rtl/redmule_stream_addrgen.sv
// ---------------------------------------------------------------------------
// redmule_stream_addrgen
//
// Two-dimensional address generator for one RedMulE stream (X/W/Y source or
// Z sink). It accepts one job from the memory scheduler per start handshake,
// emits a valid/ready address stream towards the TCDM streamer, and then
// pulses done_o for one cycle. That pulse advances the scheduler's iteration
// counters.
//
// Addresses follow base + i0*d0_stride + i1*d1_stride. They are built with
// running accumulators, so no multipliers are needed. All arithmetic wraps
// modulo 2^AW.
//
// Parameters
//   AW : address width
//   LW : width of tot_len, d0_len and d1_len
//
// Ports
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : synchronous soft clear (same effect as reset, aborts a job)
//   req_start_i     : job start request, honoured only while idle
//   ready_start_o   : idle, a job can be accepted
//   base_addr_i     : job base address
//   tot_len_i       : total number of addresses to emit
//   d0_len_i/_stride: inner dimension length / byte stride
//   d1_len_i/_stride: outer dimension length / byte stride
//   addr_o          : current address
//   addr_valid_o    : addr_o valid
//   addr_ready_i    : downstream accepts addr_o
//   done_o          : one-cycle pulse on job completion
//   busy_o          : job in progress (RUN or DONE)
//   perf_stall_o    : only with REDMULE_ADDRGEN_PERF_EN; counts stalled RUN cycles
//
// Optional feature macro: REDMULE_ADDRGEN_PERF_EN
// ---------------------------------------------------------------------------
module redmule_stream_addrgen #(
  parameter int unsigned AW = 32,
  parameter int unsigned LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_start_i,
  output logic          ready_start_o,
  input  logic [AW-1:0] base_addr_i,
  input  logic [LW-1:0] tot_len_i,
  input  logic [LW-1:0] d0_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [LW-1:0] d1_len_i,
  input  logic [AW-1:0] d1_stride_i,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i,
  output logic          done_o,
`ifdef REDMULE_ADDRGEN_PERF_EN
  output logic [31:0]   perf_stall_o,
`endif
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [AW-1:0] r_base;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_row_base;
  logic [AW-1:0] r_d0_stride;
  logic [AW-1:0] r_d1_stride;
  logic [LW-1:0] r_d0_last;
  logic [LW-1:0] r_d1_last;
  logic [LW-1:0] r_tot_len;
  logic [LW-1:0] r_i0;
  logic [LW-1:0] r_i1;
  logic [LW-1:0] r_beat_cnt;

  logic w_start;
  logic w_beat;
  logic w_last_beat;

  assign w_start     = (r_state == IDLE) && req_start_i;
  assign w_beat      = (r_state == RUN) && addr_ready_i;
  // tot_len is never zero while in RUN, so tot_len-1 cannot underflow here.
  assign w_last_beat = w_beat && (r_beat_cnt == (r_tot_len - LW'(1)));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else if (clear_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_next  = r_state;
    ready_start_o = 1'b0;
    addr_valid_o  = 1'b0;
    done_o        = 1'b0;
    busy_o        = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready_start_o = 1'b1;
        if (req_start_i) begin
          w_state_next = (tot_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        addr_valid_o = 1'b1;
        busy_o       = 1'b1;
        if (w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done_o       = 1'b1;
        busy_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Job latch and 2-D accumulators. r_row_base tracks base + i1*d1_stride so
  // that an inner-dimension wrap can jump to the next row in one add.
  // A zero length is stored as a last index of 0, which makes it behave as 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base      <= '0;
      r_addr      <= '0;
      r_row_base  <= '0;
      r_d0_stride <= '0;
      r_d1_stride <= '0;
      r_d0_last   <= '0;
      r_d1_last   <= '0;
      r_tot_len   <= '0;
      r_i0        <= '0;
      r_i1        <= '0;
      r_beat_cnt  <= '0;
    end else if (clear_i) begin
      r_base      <= '0;
      r_addr      <= '0;
      r_row_base  <= '0;
      r_d0_stride <= '0;
      r_d1_stride <= '0;
      r_d0_last   <= '0;
      r_d1_last   <= '0;
      r_tot_len   <= '0;
      r_i0        <= '0;
      r_i1        <= '0;
      r_beat_cnt  <= '0;
    end else if (w_start) begin
      r_base      <= base_addr_i;
      r_addr      <= base_addr_i;
      r_row_base  <= base_addr_i;
      r_d0_stride <= d0_stride_i;
      r_d1_stride <= d1_stride_i;
      r_d0_last   <= (d0_len_i == '0) ? '0 : (d0_len_i - LW'(1));
      r_d1_last   <= (d1_len_i == '0) ? '0 : (d1_len_i - LW'(1));
      r_tot_len   <= tot_len_i;
      r_i0        <= '0;
      r_i1        <= '0;
      r_beat_cnt  <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + LW'(1);
      if (r_i0 == r_d0_last) begin
        r_i0 <= '0;
        if (r_i1 == r_d1_last) begin
          // Whole pattern done: start over from base if beats remain.
          r_i1       <= '0;
          r_row_base <= r_base;
          r_addr     <= r_base;
        end else begin
          r_i1       <= r_i1 + LW'(1);
          r_row_base <= r_row_base + r_d1_stride;
          r_addr     <= r_row_base + r_d1_stride;
        end
      end else begin
        r_i0   <= r_i0 + LW'(1);
        r_addr <= r_addr + r_d0_stride;
      end
    end
  end

  assign addr_o = r_addr;

`ifdef REDMULE_ADDRGEN_PERF_EN
  logic [31:0] r_perf_stall;

  // Stall counter: saturating, restarted by each job, frozen once RUN ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_stall <= '0;
    end else if (clear_i) begin
      r_perf_stall <= '0;
    end else if (w_start) begin
      r_perf_stall <= '0;
    end else if ((r_state == RUN) && !addr_ready_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// ---------------------------------------------------------------------------
// tb_redmule_stream_addrgen
//
// Directed testbench for redmule_stream_addrgen. One initial block walks
// through reset, the basic 1-D and 2-D patterns, early end and pattern
// repeat, a zero-length job, back-pressure, soft clear, zero lengths and
// input changes after the start handshake. Expected values are written out
// by hand for each step.
// ---------------------------------------------------------------------------
module tb_redmule_stream_addrgen;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;

  logic          clk_i;
  logic          rst_ni;
  logic          clear_i;
  logic          req_start_i;
  logic          ready_start_o;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] tot_len_i;
  logic [LW-1:0] d0_len_i;
  logic [AW-1:0] d0_stride_i;
  logic [LW-1:0] d1_len_i;
  logic [AW-1:0] d1_stride_i;
  logic [AW-1:0] addr_o;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic          done_o;
  logic          busy_o;
`ifdef REDMULE_ADDRGEN_PERF_EN
  logic [31:0]   perf_stall_o;
`endif

  int nCompared;
  int nMismatched;

  redmule_stream_addrgen #(
    .AW(AW),
    .LW(LW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .req_start_i  (req_start_i),
    .ready_start_o(ready_start_o),
    .base_addr_i  (base_addr_i),
    .tot_len_i    (tot_len_i),
    .d0_len_i     (d0_len_i),
    .d0_stride_i  (d0_stride_i),
    .d1_len_i     (d1_len_i),
    .d1_stride_i  (d1_stride_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .done_o       (done_o),
`ifdef REDMULE_ADDRGEN_PERF_EN
    .perf_stall_o (perf_stall_o),
`endif
    .busy_o       (busy_o)
  );

  // 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just after the edge before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a job for one cycle, then scramble the job inputs so any
  // late sampling by the design would show up as wrong addresses.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] tot,
                               input logic [LW-1:0] d0l, input logic [AW-1:0] d0s,
                               input logic [LW-1:0] d1l, input logic [AW-1:0] d1s);
    base_addr_i = base;
    tot_len_i   = tot;
    d0_len_i    = d0l;
    d0_stride_i = d0s;
    d1_len_i    = d1l;
    d1_stride_i = d1s;
    req_start_i = 1'b1;
    step();
    req_start_i = 1'b0;
    base_addr_i = 32'hDEAD_BEEF;
    tot_len_i   = 16'h7777;
    d0_len_i    = 16'h0005;
    d0_stride_i = 32'h0000_0333;
    d1_len_i    = 16'h0009;
    d1_stride_i = 32'h0000_5555;
  endtask

  logic [31:0] expT1 [4];
  logic [31:0] expT3 [8];

  initial begin
    nCompared    = 0;
    nMismatched  = 0;
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    req_start_i  = 1'b0;
    addr_ready_i = 1'b1;
    base_addr_i  = '0;
    tot_len_i    = '0;
    d0_len_i     = '0;
    d0_stride_i  = '0;
    d1_len_i     = '0;
    d1_stride_i  = '0;

    expT1[0] = 32'h1000; expT1[1] = 32'h1040; expT1[2] = 32'h1080; expT1[3] = 32'h10C0;
    expT3[0] = 32'h000;  expT3[1] = 32'h004;  expT3[2] = 32'h008;  expT3[3] = 32'h100;
    expT3[4] = 32'h104;  expT3[5] = 32'h108;  expT3[6] = 32'h000;  expT3[7] = 32'h004;

    // Reset state.
    #12;
    checkOutput("rst_ready_start", 32'(ready_start_o), 32'd1);
    checkOutput("rst_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_addr", addr_o, 32'h0);
    rst_ni = 1'b1;
    step();

    // T1: pure outer-dimension walk, four consecutive beats then done.
    $display("[TB] T1 1-D outer walk");
    applyStimulus(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h40);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_valid%0d", i), 32'(addr_valid_o), 32'd1);
      checkOutput($sformatf("t1_addr%0d", i), addr_o, expT1[i]);
      checkOutput($sformatf("t1_done%0d", i), 32'(done_o), 32'd0);
      step();
    end
    checkOutput("t1_done", 32'(done_o), 32'd1);
    checkOutput("t1_done_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("t1_done_busy", 32'(busy_o), 32'd1);
    step();
    checkOutput("t1_done_pulse", 32'(done_o), 32'd0);
    checkOutput("t1_idle_ready", 32'(ready_start_o), 32'd1);
    checkOutput("t1_idle_busy", 32'(busy_o), 32'd0);

    // T2: 3x2 pattern, exact length. A held req_start during RUN must be ignored.
    $display("[TB] T2 2-D pattern");
    applyStimulus(32'h0, 16'd6, 16'd3, 32'h4, 16'd2, 32'h100);
    req_start_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t2_valid%0d", i), 32'(addr_valid_o), 32'd1);
      checkOutput($sformatf("t2_addr%0d", i), addr_o, expT3[i]);
      checkOutput($sformatf("t2_rdy_start%0d", i), 32'(ready_start_o), 32'd0);
      step();
    end
    req_start_i = 1'b0;
    checkOutput("t2_done", 32'(done_o), 32'd1);
    step();
    checkOutput("t2_idle", 32'(ready_start_o), 32'd1);

    // T3: tot_len beyond the pattern, sequence wraps back to base.
    $display("[TB] T3 pattern repeat");
    applyStimulus(32'h0, 16'd8, 16'd3, 32'h4, 16'd2, 32'h100);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3_addr%0d", i), addr_o, expT3[i]);
      checkOutput($sformatf("t3_valid%0d", i), 32'(addr_valid_o), 32'd1);
      step();
    end
    checkOutput("t3_done", 32'(done_o), 32'd1);
    step();

    // Early end: tot_len smaller than the 3x2 pattern.
    $display("[TB] early end");
    applyStimulus(32'h0, 16'd4, 16'd3, 32'h4, 16'd2, 32'h100);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("early_addr%0d", i), addr_o, expT3[i]);
      step();
    end
    checkOutput("early_done", 32'(done_o), 32'd1);
    checkOutput("early_valid", 32'(addr_valid_o), 32'd0);
    step();

    // T4: zero-length job goes straight to DONE.
    $display("[TB] T4 zero length");
    applyStimulus(32'h3000, 16'd0, 16'd2, 32'h4, 16'd2, 32'h10);
    checkOutput("t4_valid_c1", 32'(addr_valid_o), 32'd0);
    checkOutput("t4_done_c1", 32'(done_o), 32'd1);
    step();
    checkOutput("t4_valid_c2", 32'(addr_valid_o), 32'd0);
    checkOutput("t4_done_c2", 32'(done_o), 32'd0);
    checkOutput("t4_ready_start", 32'(ready_start_o), 32'd1);

    // T5: T1 with addr_ready_i low for three cycles on beat 2.
    $display("[TB] T5 back-pressure");
    applyStimulus(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h40);
    checkOutput("t5_addr0", addr_o, 32'h1000);
    step();
    addr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t5_stall_addr%0d", i), addr_o, 32'h1040);
      checkOutput($sformatf("t5_stall_valid%0d", i), 32'(addr_valid_o), 32'd1);
      step();
    end
    addr_ready_i = 1'b1;
    checkOutput("t5_addr1", addr_o, 32'h1040);
    step();
    checkOutput("t5_addr2", addr_o, 32'h1080);
    step();
    checkOutput("t5_addr3", addr_o, 32'h10C0);
    step();
    checkOutput("t5_done", 32'(done_o), 32'd1);
`ifdef REDMULE_ADDRGEN_PERF_EN
    checkOutput("t5_perf_done", perf_stall_o, 32'd3);
`endif
    step();
`ifdef REDMULE_ADDRGEN_PERF_EN
    checkOutput("t5_perf_held", perf_stall_o, 32'd3);
`endif
    checkOutput("t5_idle", 32'(ready_start_o), 32'd1);

    // T6: clear after beat 2 aborts the job without done.
    $display("[TB] T6 soft clear");
    applyStimulus(32'h1000, 16'd4, 16'd1, 32'h0, 16'd4, 32'h40);
    checkOutput("t6_addr0", addr_o, 32'h1000);
    step();
    checkOutput("t6_addr1", addr_o, 32'h1040);
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checkOutput("t6_valid", 32'(addr_valid_o), 32'd0);
    checkOutput("t6_done", 32'(done_o), 32'd0);
    checkOutput("t6_ready_start", 32'(ready_start_o), 32'd1);
    checkOutput("t6_busy", 32'(busy_o), 32'd0);
    step();
    checkOutput("t6_done_late", 32'(done_o), 32'd0);
    applyStimulus(32'h2000, 16'd2, 16'd1, 32'h0, 16'd2, 32'h10);
    checkOutput("t6_new_addr0", addr_o, 32'h2000);
    step();
    checkOutput("t6_new_addr1", addr_o, 32'h2010);
    step();
    checkOutput("t6_new_done", 32'(done_o), 32'd1);
    step();

    // Zero lengths behave as 1: every beat lands on base.
    $display("[TB] zero dimension lengths");
    applyStimulus(32'h4000, 16'd3, 16'd0, 32'h8, 16'd0, 32'h80);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("zlen_addr%0d", i), addr_o, 32'h4000);
      step();
    end
    checkOutput("zlen_done", 32'(done_o), 32'd1);
    step();

    // Address arithmetic wraps modulo 2^AW.
    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFF8, 16'd3, 16'd3, 32'h8, 16'd1, 32'h0);
    checkOutput("wrap_addr0", addr_o, 32'hFFFF_FFF8);
    step();
    checkOutput("wrap_addr1", addr_o, 32'h0000_0000);
    step();
    checkOutput("wrap_addr2", addr_o, 32'h0000_0008);
    step();
    checkOutput("wrap_done", 32'(done_o), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
